wb_spimemio_cache: RTL and testbench

Read-only, direct-mapped word cache between the CPU instruction/data Wishbone master and the SPI flash Wishbone slave (wb_spimemio). Hits return in one cycle and avoid a slow flash transfer of about 130 clocks. Misses issue exactly one single-word read downstream, fill the line, and forward the data. Flash contents are static, so there is no write path. A flush input invalidates every line after a flash reprogram.

---
 rtl/wb_spimemio_cache_pkg.sv | 29 ++
 rtl/wb_spimemio_cache_ram.sv | 62 ++++++
 rtl/wb_spimemio_cache.sv | 135 +++++++++++++
 tb/tb_wb_spimemio_cache.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_spimemio_cache_pkg.sv
// wb_spimemio_cache_pkg
//   Shared types and constants for the SPI flash read cache.
//   - state_e          : controller state (IDLE, FILL)
//   - WORD_ALIGN_BITS  : byte-offset bits dropped from every address
//   - clog2()          : elaboration-time log2 used to size the line index

package wb_spimemio_cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    localparam int WORD_ALIGN_BITS = 2;

    // Ceiling log2; only ever called with constant arguments.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/wb_spimemio_cache_ram.sv
// wb_spimemio_cache_ram
//   LINES x (valid + tag + 32-bit data) line storage for the flash cache.
//   Ports:
//     clk_i       clock
//     clear_i     synchronous clear of every valid bit (reset or flush)
//     rd_idx_i    asynchronous read index
//     rd_valid_o  valid bit of the addressed line
//     rd_tag_o    tag of the addressed line
//     rd_data_o   data word of the addressed line
//     wr_en_i     synchronous write strobe
//     wr_idx_i    write index
//     wr_valid_i  valid bit to store
//     wr_tag_i    tag to store
//     wr_data_i   data word to store

module wb_spimemio_cache_ram #(
    parameter int LINES = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 18
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [31:0]      rd_data_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_valid_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [31:0]      wr_data_i
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    // Clear has priority so a flush landing on a fill-completion edge
    // leaves the line invalid.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= wr_valid_i;
        end
    end

    // NOTE: only the valid bits are reset; tag and data arrays stay
    // unreset so they can map onto plain RAM, and a line is never used
    // while its valid bit is clear.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/wb_spimemio_cache.sv
// wb_spimemio_cache
//   Read-only direct-mapped word cache between the CPU Wishbone master and
//   the SPI flash Wishbone slave. Hits ack one cycle after the request;
//   misses issue one downstream word read, fill the line and forward data.
//   Ports:
//     wb_clk_i   clock
//     wb_rst_i   synchronous active-high reset
//     wbs_*      upstream slave side (adr/cyc/stb in, dat/ack out)
//     wbm_*      downstream master side (adr/cyc/stb out, dat/ack in)
//     flush_i    one-cycle pulse that invalidates every line

module wb_spimemio_cache
    import wb_spimemio_cache_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int ADDR_W = 24
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [ADDR_W-1:0] wbs_adr_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    output logic [31:0]       wbs_dat_o,
    output logic              wbs_ack_o,
    output logic [ADDR_W-1:0] wbm_adr_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    input  logic [31:0]       wbm_dat_i,
    input  logic              wbm_ack_i,
    input  logic              flush_i
);

    localparam int IDX_W = clog2(LINES);
    localparam int TAG_W = ADDR_W - WORD_ALIGN_BITS - IDX_W;
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << WORD_ALIGN_BITS) - 1);

    state_e            state_q;
    logic              ack_q;
    logic [31:0]       dat_q;
    logic              dn_cyc_q;
    logic [ADDR_W-1:0] dn_adr_q;
    // Set when a flush overlaps the in-flight fill: the returning word may
    // predate the reprogram, so it is forwarded but not kept.
    logic              fill_inval_q;

    logic              req;
    logic              hit;
    logic              fill_done;
    logic [ADDR_W-1:0] req_word_adr;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [31:0]       rd_data;

    // The !ack term keeps a strobe still held in the ack cycle from being
    // taken as a second request.
    assign req          = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign req_word_adr = wbs_adr_i & ~OFFSET_MASK;
    assign req_idx      = wbs_adr_i[WORD_ALIGN_BITS +: IDX_W];
    assign req_tag      = wbs_adr_i[ADDR_W-1 -: TAG_W];
    assign hit          = rd_valid & (rd_tag == req_tag);
    assign fill_done    = (state_q == FILL) & wbm_ack_i;

    wb_spimemio_cache_ram #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_ram (
        .clk_i      (wb_clk_i),
        .clear_i    (wb_rst_i | flush_i),
        .rd_idx_i   (req_idx),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (fill_done & ~wb_rst_i),
        .wr_idx_i   (dn_adr_q[WORD_ALIGN_BITS +: IDX_W]),
        .wr_valid_i (~(fill_inval_q | flush_i)),
        .wr_tag_i   (dn_adr_q[ADDR_W-1 -: TAG_W]),
        .wr_data_i  (wbm_dat_i)
    );

    // NOTE: all state here is sequential, so every assignment is
    // non-blocking; later reads in the block see the pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            ack_q        <= 1'b0;
            dat_q        <= '0;
            dn_cyc_q     <= 1'b0;
            dn_adr_q     <= '0;
            fill_inval_q <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (hit) begin
                            ack_q <= 1'b1;
                            dat_q <= rd_data;
                        end else begin
                            dn_adr_q     <= req_word_adr;
                            dn_cyc_q     <= 1'b1;
                            // A flush on the accepting edge also poisons the fill.
                            fill_inval_q <= flush_i;
                            state_q      <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (flush_i) begin
                        fill_inval_q <= 1'b1;
                    end
                    if (wbm_ack_i) begin
                        dn_cyc_q <= 1'b0;
                        state_q  <= IDLE;
                        // Forward only if the master is still waiting.
                        if (wbs_cyc_i & wbs_stb_i) begin
                            ack_q <= 1'b1;
                            dat_q <= wbm_dat_i;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign wbm_cyc_o = dn_cyc_q;
    assign wbm_stb_o = dn_cyc_q;
    assign wbm_adr_o = dn_adr_q;

endmodule

// File: tb/tb_wb_spimemio_cache.sv
// tb_wb_spimemio_cache
//   Self-checking bench for wb_spimemio_cache. The bench plays both the CPU
//   master and the flash slave, and keeps a reference model of which word
//   address each line currently holds.

module tb_wb_spimemio_cache;

    localparam int LINES  = 16;
    localparam int ADDR_W = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] wbs_adr;
    logic              wbs_cyc;
    logic              wbs_stb;
    logic [31:0]       wbs_dat_o;
    logic              wbs_ack_o;
    logic [ADDR_W-1:0] wbm_adr_o;
    logic              wbm_cyc_o;
    logic              wbm_stb_o;
    logic [31:0]       wbm_dat;
    logic              wbm_ack;
    logic              flush;

    int checks    = 0;
    int errors    = 0;
    int exp_reads = 0;
    int dn_reads  = 0;
    int dbl_acks  = 0;
    logic cyc_prev = 1'b0;
    logic ack_prev = 1'b0;

    logic [31:0] seed;

    // Reference model: which word address each line holds, if any.
    bit                mvalid [LINES];
    logic [ADDR_W-1:0] mline  [LINES];

    always #5 clk = ~clk;

    wb_spimemio_cache #(
        .LINES  (LINES),
        .ADDR_W (ADDR_W)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_adr_i (wbs_adr),
        .wbs_cyc_i (wbs_cyc),
        .wbs_stb_i (wbs_stb),
        .wbs_dat_o (wbs_dat_o),
        .wbs_ack_o (wbs_ack_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_dat_i (wbm_dat),
        .wbm_ack_i (wbm_ack),
        .flush_i   (flush)
    );

    // Observers: count downstream read starts and back-to-back upstream acks.
    always @(negedge clk) begin
        if (wbm_cyc_o === 1'b1 && cyc_prev !== 1'b1) dn_reads++;
        if (wbs_ack_o === 1'b1 && ack_prev === 1'b1) dbl_acks++;
        cyc_prev = wbm_cyc_o;
        ack_prev = wbs_ack_o;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] flash_word(input logic [ADDR_W-1:0] wa);
        if (wa == 24'h000104) return 32'hDEADBEEF;
        if (wa == 24'h000144) return 32'h11223344;
        return {wa[15:0], wa[23:16] ^ 8'hA5, 8'h3C} ^ seed;
    endfunction

    function automatic int idx_of(input logic [ADDR_W-1:0] wa);
        return int'((wa >> 2) % LINES);
    endfunction

    function automatic bit model_hit(input logic [ADDR_W-1:0] wa);
        return mvalid[idx_of(wa)] && (mline[idx_of(wa)] == wa);
    endfunction

    task automatic model_flush();
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_flush();
    endtask

    // One CPU read. lat: downstream latency in cycles; flush_at / abort_at:
    // FILL cycle at which to pulse flush / drop upstream cyc (-1 = never);
    // wiggle: scramble the upstream address while the fill is pending.
    task automatic cpu_read(input logic [ADDR_W-1:0] a, input int lat,
                            input int flush_at, input int abort_at, input bit wiggle);
        logic [ADDR_W-1:0] wa;
        logic [31:0]       d;
        bit                stable;
        bit                early;
        bit                up;
        bit                flushed;
        wa = a & ~24'h3;
        d  = flash_word(wa);
        @(negedge clk);
        wbs_adr = a;
        wbs_cyc = 1'b1;
        wbs_stb = 1'b1;
        if (model_hit(wa)) begin
            @(negedge clk);
            check("hit_ack", wbs_ack_o, 1);
            check("hit_dat", wbs_dat_o, d);
            check("hit_no_downstream", wbm_cyc_o, 0);
            wbs_cyc = 1'b0;
            wbs_stb = 1'b0;
            @(negedge clk);
            check("hit_ack_fall", wbs_ack_o, 0);
        end else begin
            exp_reads++;
            stable  = 1'b1;
            early   = 1'b0;
            up      = 1'b1;
            flushed = 1'b0;
            for (int i = 0; i < lat; i++) begin
                @(negedge clk);
                if (!(wbm_cyc_o === 1'b1 && wbm_stb_o === 1'b1 && wbm_adr_o === wa)) stable = 1'b0;
                if (wbs_ack_o !== 1'b0) early = 1'b1;
                flush = (i == flush_at);
                if (i == flush_at) flushed = 1'b1;
                if (i == abort_at) begin
                    wbs_cyc = 1'b0;
                    wbs_stb = 1'b0;
                    up      = 1'b0;
                end
                if (wiggle) wbs_adr = ADDR_W'($urandom);
                if (i == lat - 1) begin
                    wbm_ack = 1'b1;
                    wbm_dat = d;
                end
            end
            @(negedge clk);
            wbm_ack = 1'b0;
            wbm_dat = $urandom;
            flush   = 1'b0;
            check("fill_hold", stable, 1);
            check("fill_no_early_ack", early, 0);
            check("fill_ack", wbs_ack_o, up);
            if (up) check("fill_dat", wbs_dat_o, d);
            check("fill_dn_drop", wbm_cyc_o, 0);
            wbs_cyc = 1'b0;
            wbs_stb = 1'b0;
            @(negedge clk);
            check("fill_ack_fall", wbs_ack_o, 0);
            if (flushed) begin
                model_flush();
            end else begin
                mvalid[idx_of(wa)] = 1'b1;
                mline[idx_of(wa)]  = wa;
            end
        end
    endtask

    initial begin
        seed    = $urandom;
        rst     = 1'b1;
        wbs_adr = '0;
        wbs_cyc = 1'b0;
        wbs_stb = 1'b0;
        wbm_dat = '0;
        wbm_ack = 1'b0;
        flush   = 1'b0;
        model_flush();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack", wbs_ack_o, 0);
        check("rst_dat", wbs_dat_o, 0);
        check("rst_wbm_cyc", wbm_cyc_o, 0);
        check("rst_wbm_stb", wbm_stb_o, 0);
        check("rst_wbm_adr", wbm_adr_o, 0);
        rst = 1'b0;

        // Cold read with slow flash, then hits including byte offset 2
        cpu_read(24'h000104, 130, -1, -1, 1'b0);
        cpu_read(24'h000104, 1, -1, -1, 1'b0);
        cpu_read(24'h000106, 1, -1, -1, 1'b0);
        check("reads_after_hits", dn_reads, exp_reads);

        // Conflict eviction on index 1
        cpu_read(24'h000144, 5, -1, -1, 1'b0);
        cpu_read(24'h000104, 5, -1, -1, 1'b0);
        check("reads_after_evict", dn_reads, exp_reads);

        // Strobe held through the ack: acks alternate, never back to back
        @(negedge clk);
        wbs_adr = 24'h000104;
        wbs_cyc = 1'b1;
        wbs_stb = 1'b1;
        @(negedge clk);
        check("held_ack0", wbs_ack_o, 1);
        @(negedge clk);
        check("held_ack1", wbs_ack_o, 0);
        @(negedge clk);
        check("held_ack2", wbs_ack_o, 1);
        check("held_dat", wbs_dat_o, 32'hDEADBEEF);
        wbs_cyc = 1'b0;
        wbs_stb = 1'b0;
        @(negedge clk);

        // Request coincident with flush sees the pre-flush (hit) state
        @(negedge clk);
        wbs_adr = 24'h000104;
        wbs_cyc = 1'b1;
        wbs_stb = 1'b1;
        flush   = 1'b1;
        @(negedge clk);
        flush   = 1'b0;
        wbs_cyc = 1'b0;
        wbs_stb = 1'b0;
        check("flush_same_cycle_ack", wbs_ack_o, 1);
        check("flush_same_cycle_dat", wbs_dat_o, 32'hDEADBEEF);
        check("flush_same_cycle_no_dn", wbm_cyc_o, 0);
        model_flush();
        @(negedge clk);

        // After flush the line misses again
        cpu_read(24'h000104, 4, -1, -1, 1'b0);
        pulse_flush();
        cpu_read(24'h000104, 4, -1, -1, 1'b0);
        check("reads_after_flush", dn_reads, exp_reads);

        // Flush mid-fill and on the completion edge: forwarded, not kept
        cpu_read(24'h000208, 6, 2, -1, 1'b0);
        cpu_read(24'h000208, 6, 5, -1, 1'b0);
        cpu_read(24'h000208, 3, -1, -1, 1'b0);
        check("reads_after_fill_flush", dn_reads, exp_reads);

        // Upstream abort mid-fill, with address wiggling: line still filled
        cpu_read(24'h00030C, 8, -1, 2, 1'b1);
        cpu_read(24'h00030C, 1, -1, -1, 1'b0);
        check("reads_after_abort", dn_reads, exp_reads);

        // Stray downstream ack while idle is ignored
        @(negedge clk);
        wbm_ack = 1'b1;
        wbm_dat = 32'hCAFEF00D;
        @(negedge clk);
        wbm_ack = 1'b0;
        check("stray_ack_no_up", wbs_ack_o, 0);
        check("stray_ack_no_dn", wbm_cyc_o, 0);
        cpu_read(24'h00030C, 1, -1, -1, 1'b0);

        // Reset in the middle of a fill
        @(negedge clk);
        wbs_adr = 24'h000410;
        wbs_cyc = 1'b1;
        wbs_stb = 1'b1;
        exp_reads++;
        repeat (3) @(negedge clk);
        check("pre_rst_fill_cyc", wbm_cyc_o, 1);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        wbs_cyc = 1'b0;
        wbs_stb = 1'b0;
        check("mid_rst_cyc", wbm_cyc_o, 0);
        check("mid_rst_stb", wbm_stb_o, 0);
        check("mid_rst_ack", wbs_ack_o, 0);
        check("mid_rst_adr", wbm_adr_o, 0);
        model_flush();
        cpu_read(24'h000104, 2, -1, -1, 1'b0);
        cpu_read(24'h00030C, 2, -1, -1, 1'b0);
        check("reads_after_reset", dn_reads, exp_reads);

        // Randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            logic [ADDR_W-1:0] a;
            int lat;
            int fa;
            int ab;
            a   = ADDR_W'(($urandom_range(0, 63) << 2) | $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a | 24'hF00000;
            lat = $urandom_range(1, 6);
            fa  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, lat - 1) : -1;
            ab  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, lat - 1) : -1;
            cpu_read(a, lat, fa, ab, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 9) == 0) pulse_flush();
        end
        check("reads_random", dn_reads, exp_reads);
        check("no_double_ack", dbl_acks, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
